// File: rtl/mem_line_resp.sv
// Memory-side cache-line responder: in-order FIFO of line requests, each answered with one
// 512-bit line from a preloadable line store once it has aged past a programmable latency.
module mem_line_resp #(
    parameter int MCNW  = 58,
    parameter int IDXW  = 10,
    parameter int DEPTH = 4,
    parameter int LATW  = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_i_valid,
    output logic             req_i_ready,
    input  logic [MCNW-1:0]  req_i_bits_mcn,
    output logic             resp_o_valid,
    input  logic             resp_o_ready,
    output logic [511:0]     resp_o_bits_data,
    input  logic             ld_i_valid,
    input  logic [IDXW-1:0]  ld_i_bits_idx,
    input  logic [511:0]     ld_i_bits_data,
    input  logic [LATW-1:0]  lat_i,
    output logic             busy_o
);

    localparam int PTRW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW  = $clog2(DEPTH + 1);
    localparam int LINES = 1 << IDXW;
    localparam logic [LATW-1:0] AGE_MAX = {LATW{1'b1}};

    typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} out_state_t;

    out_state_t        state_q, state_d;
    logic [PTRW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]   count_q, count_d;
    logic [511:0]      data_q;
    logic [511:0]      store_mem [LINES];

    logic [DEPTH-1:0][LATW-1:0] age_all;
    logic [DEPTH-1:0][IDXW-1:0] idx_all;

    logic              push;
    logic              load;
    logic              head_elig;
    logic [LATW-1:0]   head_age;
    logic [IDXW-1:0]   head_idx;
    logic              unused_mcn_hi;

    // Upper mcn bits alias onto the store; they are deliberately dropped.
    assign unused_mcn_hi = ^req_i_bits_mcn[MCNW-1:IDXW];

    // Per-entry age/index slots; every slot ages each cycle, a push restarts its slot at 0.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
            logic [LATW-1:0] age_q, age_d;
            logic [IDXW-1:0] idx_q, idx_d;

            always_comb begin
                age_d = age_q;
                idx_d = idx_q;
                if (push && (wr_ptr_q == PTRW'(gi))) begin
                    age_d = '0;
                    idx_d = req_i_bits_mcn[IDXW-1:0];
                end else if (age_q != AGE_MAX) begin
                    age_d = age_q + 1'b1;
                end
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    age_q <= '0;
                    idx_q <= '0;
                end else begin
                    age_q <= age_d;
                    idx_q <= idx_d;
                end
            end

            assign age_all[gi] = age_q;
            assign idx_all[gi] = idx_q;
        end
    endgenerate

    assign head_age = age_all[rd_ptr_q];
    assign head_idx = idx_all[rd_ptr_q];

    // Queue control: ready depends only on registered count, never on resp_o_ready.
    always_comb begin
        push      = req_i_valid && (count_q != CNTW'(DEPTH));
        head_elig = (count_q != '0) && (head_age >= lat_i);
        load      = head_elig && ((state_q == ST_EMPTY) || resp_o_ready);
        wr_ptr_d  = wr_ptr_q + PTRW'(push);
        rd_ptr_d  = rd_ptr_q + PTRW'(load);
        count_d   = count_q + CNTW'(push) - CNTW'(load);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Output stage FSM: state register.
    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_EMPTY;
        else       state_q <= state_d;
    end

    // Output stage FSM: next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (load) state_d = ST_FULL;
            ST_FULL: begin
                if (load)              state_d = ST_FULL;
                else if (resp_o_ready) state_d = ST_EMPTY;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Output stage FSM: outputs.
    always_comb begin
        resp_o_valid     = (state_q == ST_FULL);
        resp_o_bits_data = data_q;
        req_i_ready      = (count_q != CNTW'(DEPTH));
        busy_o           = (count_q != '0) || (state_q == ST_FULL);
    end

    // Line store: preload write port, not reset.
    always_ff @(posedge clock) begin
        if (ld_i_valid) store_mem[ld_i_bits_idx] <= ld_i_bits_data;
    end

    // Registered read into the response register; a same-edge preload is not yet visible,
    // so a colliding load returns the old line.
    always_ff @(posedge clock) begin
        if (reset)     data_q <= '0;
        else if (load) data_q <= store_mem[head_idx];
    end

endmodule

// File: tb/tb_mem_line_resp.sv
// Directed bench for mem_line_resp: latency, ordering, backpressure, read-before-write,
// reset discard, mcn aliasing and mid-flight latency change.
module tb_mem_line_resp;

    localparam int MCNW = 58;
    localparam int IDXW = 10;
    localparam int LATW = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_i_valid;
    logic             req_i_ready;
    logic [MCNW-1:0]  req_i_bits_mcn;
    logic             resp_o_valid;
    logic             resp_o_ready;
    logic [511:0]     resp_o_bits_data;
    logic             ld_i_valid;
    logic [IDXW-1:0]  ld_i_bits_idx;
    logic [511:0]     ld_i_bits_data;
    logic [LATW-1:0]  lat_i;
    logic             busy_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_line_resp #(.MCNW(MCNW), .IDXW(IDXW), .DEPTH(4), .LATW(LATW)) dut (
        .clock           (clk),
        .reset           (reset),
        .req_i_valid     (req_i_valid),
        .req_i_ready     (req_i_ready),
        .req_i_bits_mcn  (req_i_bits_mcn),
        .resp_o_valid    (resp_o_valid),
        .resp_o_ready    (resp_o_ready),
        .resp_o_bits_data(resp_o_bits_data),
        .ld_i_valid      (ld_i_valid),
        .ld_i_bits_idx   (ld_i_bits_idx),
        .ld_i_bits_data  (ld_i_bits_data),
        .lat_i           (lat_i),
        .busy_o          (busy_o)
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    function automatic logic [511:0] mk_line(input int k);
        logic [31:0] w;
        w = 32'hC0DE_0000 + k[31:0];
        return {16{w}};
    endfunction

    // Advance one clock; inputs and samples happen 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int idx, input logic [511:0] d);
        ld_i_valid     = 1'b1;
        ld_i_bits_idx  = idx[IDXW-1:0];
        ld_i_bits_data = d;
        step();
        ld_i_valid     = 1'b0;
    endtask

    // Steps until resp_o_valid, counting cycles into cyc; bounded.
    task automatic wait_valid(inout int cyc);
        while (!resp_o_valid && cyc < 200) begin
            step();
            cyc++;
        end
    endtask

    logic [511:0] exp_q[$];
    logic [511:0] held;
    logic [511:0] lineA;
    int cyc, n_got, first_c, last_c, acc, stable;

    initial begin
        reset = 1'b1; req_i_valid = 1'b0; req_i_bits_mcn = '0; resp_o_ready = 1'b0;
        ld_i_valid = 1'b0; ld_i_bits_idx = '0; ld_i_bits_data = '0; lat_i = '0;
        step(); step(); step();
        reset = 1'b0;
        step();
        chk("rst_valid", 512'(resp_o_valid), 512'(0));
        chk("rst_data", resp_o_bits_data, 512'(0));
        chk("rst_busy", 512'(busy_o), 512'(0));
        chk("rst_ready", 512'(req_i_ready), 512'(1));

        // 1: single request, lat 3 -> valid 5 cycles after acceptance, one beat.
        preload(5, {64{8'hA5}});
        lat_i = 8'd3;
        req_i_valid = 1'b1; req_i_bits_mcn = 58'd5;
        step();
        req_i_valid = 1'b0;
        cyc = 1;
        wait_valid(cyc);
        chk("t1_latency", 512'(cyc), 512'(5));
        chk("t1_data", resp_o_bits_data, {64{8'hA5}});
        resp_o_ready = 1'b1;
        step();
        chk("t1_one_beat", 512'(resp_o_valid), 512'(0));
        chk("t1_idle", 512'(busy_o), 512'(0));

        // 2: lat 0, four back-to-back requests -> four consecutive in-order responses.
        for (int k = 1; k <= 8; k++) preload(k, mk_line(k));
        lat_i = '0;
        resp_o_ready = 1'b1;
        for (int k = 1; k <= 4; k++) exp_q.push_back(mk_line(k));
        n_got = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < 12; c++) begin
            if (c < 4) begin
                req_i_valid = 1'b1;
                req_i_bits_mcn = MCNW'(c + 1);
                chk($sformatf("t2_ready_c%0d", c), 512'(req_i_ready), 512'(1));
            end else begin
                req_i_valid = 1'b0;
            end
            if (resp_o_valid) begin
                chk($sformatf("t2_data%0d", n_got), resp_o_bits_data,
                    (exp_q.size() != 0) ? exp_q.pop_front() : 512'(0));
                if (first_c < 0) first_c = c;
                last_c = c;
                n_got++;
            end
            step();
        end
        chk("t2_count", 512'(n_got), 512'(4));
        chk("t2_span", 512'(last_c - first_c), 512'(3));

        // 3: backpressure, 8 offered -> 5 accepted, output held, then 5 in-order responses.
        resp_o_ready = 1'b0;
        acc = 0;
        for (int k = 1; k <= 8; k++) begin
            req_i_valid = 1'b1;
            req_i_bits_mcn = MCNW'(k);
            if (req_i_ready) acc++;
            step();
        end
        req_i_valid = 1'b0;
        chk("t3_accepted", 512'(acc), 512'(5));
        chk("t3_ready_low", 512'(req_i_ready), 512'(0));
        held = resp_o_bits_data;
        chk("t3_held_data", held, mk_line(1));
        stable = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (resp_o_valid && resp_o_bits_data === held) stable++;
        end
        chk("t3_stable", 512'(stable), 512'(10));
        resp_o_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            cyc = 0;
            wait_valid(cyc);
            chk($sformatf("t3_resp%0d", k), resp_o_bits_data, mk_line(k));
            step();
        end
        chk("t3_drained", 512'(resp_o_valid), 512'(0));
        chk("t3_ready_back", 512'(req_i_ready), 512'(1));

        // 4: preload coinciding with head load -> old data, next request sees new data.
        lineA = {16{32'hDEAD_BEEF}};
        req_i_valid = 1'b1; req_i_bits_mcn = 58'd7;
        step();
        req_i_valid = 1'b0;
        ld_i_valid = 1'b1; ld_i_bits_idx = 10'd7; ld_i_bits_data = lineA;
        step();
        ld_i_valid = 1'b0;
        chk("t4_valid", 512'(resp_o_valid), 512'(1));
        chk("t4_old_data", resp_o_bits_data, mk_line(7));
        step();
        req_i_valid = 1'b1; req_i_bits_mcn = 58'd7;
        step();
        req_i_valid = 1'b0;
        cyc = 1;
        wait_valid(cyc);
        chk("t4_new_data", resp_o_bits_data, lineA);
        step();

        // 5: reset with three outstanding discards them all.
        resp_o_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            req_i_valid = 1'b1; req_i_bits_mcn = MCNW'(k);
            step();
        end
        req_i_valid = 1'b0;
        chk("t5_busy_pre", 512'(busy_o), 512'(1));
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t5_valid", 512'(resp_o_valid), 512'(0));
        chk("t5_busy", 512'(busy_o), 512'(0));
        chk("t5_ready", 512'(req_i_ready), 512'(1));
        resp_o_ready = 1'b1;
        stable = 0;
        for (int k = 0; k < 20; k++) begin
            if (resp_o_valid) stable++;
            step();
        end
        chk("t5_no_stale", 512'(stable), 512'(0));

        // 6a: mcn aliasing onto index 5.
        req_i_valid = 1'b1; req_i_bits_mcn = (MCNW'(1) << IDXW) | MCNW'(5);
        step();
        req_i_valid = 1'b0;
        cyc = 1;
        wait_valid(cyc);
        chk("t6_alias_lat", 512'(cyc), 512'(2));
        chk("t6_alias_data", resp_o_bits_data, mk_line(5));
        step();

        // 6b: latency raised 0->20 while the queued entry is age 4.
        resp_o_ready = 1'b0;
        req_i_valid = 1'b1; req_i_bits_mcn = 58'd2;
        step();
        req_i_bits_mcn = 58'd3;
        step();
        req_i_valid = 1'b0;
        for (int k = 0; k < 4; k++) step();
        chk("t6_blocker", resp_o_bits_data, mk_line(2));
        lat_i = 8'd20;
        resp_o_ready = 1'b1;
        cyc = 5;
        step();
        cyc++;
        wait_valid(cyc);
        chk("t6_lat20", 512'(cyc), 512'(22));
        chk("t6_lat20_data", resp_o_bits_data, mk_line(3));
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
